ps2_host_ctrl: RTL and testbench

Bidirectional PS/2 host controller for PicoSoC that owns the shared ps2_clk/ps2_data open-drain lines.
- Receives device frames into an RX FIFO.
- Sequences host-to-device command transmission: clock inhibit, request-to-send, bit drive, ACK check.
- Arbitrates line ownership between RX and TX.
- Attaches to the SoC bus as a data register and a status register.

---
 rtl/ps2_host_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: PS/2 host; raw ps2_clk_i/ps2_data_i in, open-drain ps2_clk_oe/ps2_data_oe out, data reg (re pops RX FIFO, we loads TX byte, wait stalls), status reg (re clears sticky bits)
module ps2_host_ctrl #(
  parameter int FILT_LEN       = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int INHIBIT_CYCLES = 1200,
  parameter int TIMEOUT_CYCLES = 24000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ps2_clk_i,
  input  logic        ps2_data_i,
  output logic        ps2_clk_oe,
  output logic        ps2_data_oe,
  input  logic        reg_dat_re,
  input  logic        reg_dat_we,
  input  logic [31:0] reg_dat_di,
  output logic [31:0] reg_dat_do,
  output logic        reg_dat_wait,
  input  logic        reg_stat_re,
  output logic [31:0] reg_stat_do
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2((TIMEOUT_CYCLES > INHIBIT_CYCLES ? TIMEOUT_CYCLES : INHIBIT_CYCLES) + 1);
  localparam int FW = $clog2(FILT_LEN + 1);
  typedef enum logic [2:0] {IDLE, RX, INHIBIT, TX, ACK, WAITHI} state_t;
  state_t st_q, st_d;
  logic [1:0] cs_q, cs_d, ds_q, ds_d;
  logic filt_q, filt_d, par_q, par_d, full_q, full_d, clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
  logic ovf_q, ovf_d, perr_q, perr_d, nack_q, nack_d, tmo_q, tmo_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d, hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic flip, fall, din, push, push_ok, pop, set_ovf, set_perr, set_nack, set_tmo;
  logic empty, ffull, tx_busy, unused_di;
  logic [8:0] tx_bits;
  assign empty = wr_q == rd_q;
  assign ffull = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign tx_bits = {~^hold_q, hold_q};
  assign tx_busy = full_q | (st_q inside {INHIBIT, TX, ACK, WAITHI});
  assign ps2_clk_oe = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign reg_dat_do = empty ? '1 : {24'h0, mem_q[rd_q[AW-1:0]]};
  assign reg_dat_wait = reg_dat_we & full_q;
  assign reg_stat_do = {26'h0, tmo_q, perr_q, nack_q, tx_busy, ovf_q, ~empty};
  assign unused_di = ^reg_dat_di[31:8];
  always_comb begin
    cs_d = {cs_q[0], ps2_clk_i};
    ds_d = {ds_q[0], ps2_data_i};
    din = ds_q[1];
    flip = cs_q[1] != filt_q && fcnt_q == FW'(FILT_LEN - 1);
    filt_d = flip ? cs_q[1] : filt_q;
    fcnt_d = (cs_q[1] == filt_q || flip) ? '0 : fcnt_q + FW'(1);
    fall = filt_q & ~filt_d;
    st_d = st_q;
    bit_d = bit_q;
    sr_d = sr_q;
    par_d = par_q;
    cnt_d = cnt_q + CW'(1);
    hold_d = hold_q;
    full_d = full_q;
    clk_oe_d = clk_oe_q;
    data_oe_d = data_oe_q;
    push = 1'b0;
    set_perr = 1'b0;
    set_nack = 1'b0;
    set_tmo = 1'b0;
    if (reg_dat_we && !full_q) begin
      hold_d = reg_dat_di[7:0];
      full_d = 1'b1;
    end
    case (st_q)
      IDLE: begin
        cnt_d = '0;
        clk_oe_d = 1'b0;
        data_oe_d = 1'b0;
        if (full_q && filt_q) begin
          st_d = INHIBIT;
          clk_oe_d = 1'b1;
        end else if (fall && !din) begin
          st_d = RX;
          bit_d = '0;
        end
      end
      RX: if (fall) begin
        bit_d = bit_q + 4'd1;
        if (bit_q < 4'd8) sr_d = {din, sr_q[7:1]};
        if (bit_q == 4'd8) par_d = din;
        if (bit_q == 4'd9) begin
          st_d = IDLE;
          push = din & ^{sr_q, par_q};
          set_perr = ~(din & ^{sr_q, par_q});
        end
      end
      INHIBIT: if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
        st_d = TX;
        clk_oe_d = 1'b0;
        data_oe_d = 1'b1;
        bit_d = '0;
        cnt_d = '0;
      end
      TX: if (fall) begin
        bit_d = bit_q + 4'd1;
        data_oe_d = (bit_q == 4'd9) ? 1'b0 : ~tx_bits[bit_q];
        if (bit_q == 4'd9) st_d = ACK;
      end
      ACK: if (fall) begin
        set_nack = din;
        full_d = 1'b0;
        st_d = WAITHI;
      end
      WAITHI: if (filt_q) st_d = IDLE;
      default: st_d = IDLE;
    endcase
    if (st_q inside {RX, TX, ACK, WAITHI}) begin
      if (fall) cnt_d = '0;
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        st_d = IDLE;
        clk_oe_d = 1'b0;
        data_oe_d = 1'b0;
        full_d = 1'b0;
        set_tmo = 1'b1;
        cnt_d = '0;
      end
    end
    pop = reg_dat_re & ~empty;
    push_ok = push & (~ffull | pop);
    set_ovf = push & ffull & ~pop;
    wr_d = push_ok ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = pop ? rd_q + (AW+1)'(1) : rd_q;
    ovf_d = set_ovf | (ovf_q & ~reg_stat_re);
    perr_d = set_perr | (perr_q & ~reg_stat_re);
    nack_d = set_nack | (nack_q & ~reg_stat_re);
    tmo_d = set_tmo | (tmo_q & ~reg_stat_re);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_q <= IDLE;
      cs_q <= 2'b11;
      ds_q <= 2'b11;
      filt_q <= 1'b1;
      fcnt_q <= '0;
      bit_q <= '0;
      sr_q <= '0;
      par_q <= 1'b0;
      cnt_q <= '0;
      hold_q <= '0;
      full_q <= 1'b0;
      clk_oe_q <= 1'b0;
      data_oe_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
      perr_q <= 1'b0;
      nack_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cs_q <= cs_d;
      ds_q <= ds_d;
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      bit_q <= bit_d;
      sr_q <= sr_d;
      par_q <= par_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      full_q <= full_d;
      clk_oe_q <= clk_oe_d;
      data_oe_q <= data_oe_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
      perr_q <= perr_d;
      nack_q <= nack_d;
      tmo_q <= tmo_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= sr_q;
  end
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: directed bench with an open-drain PS/2 device model for ps2_host_ctrl
module tb_ps2_host_ctrl;
  logic clk = 1'b0, resetn = 1'b0, dev_clk = 1'b1, dev_dat = 1'b1;
  logic reg_dat_re = 1'b0, reg_dat_we = 1'b0, reg_stat_re = 1'b0;
  logic [31:0] reg_dat_di = '0;
  logic ps2_clk_i, ps2_data_i, ps2_clk_oe, ps2_data_oe, reg_dat_wait;
  logic [31:0] reg_dat_do, reg_stat_do;
  int checks = 0, failures = 0;
  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_data_i = dev_dat & ~ps2_data_oe;
  always #5 clk = ~clk;
  ps2_host_ctrl dut (
    .clk(clk), .resetn(resetn), .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .reg_dat_re(reg_dat_re),
    .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di), .reg_dat_do(reg_dat_do),
    .reg_dat_wait(reg_dat_wait), .reg_stat_re(reg_stat_re), .reg_stat_do(reg_stat_do)
  );
  typedef struct {
    logic [7:0] d;
    logic p;
    logic s;
    logic [31:0] exp_do;
    logic exp_perr;
  } rx_vec_t;
  rx_vec_t rxv[7];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
    return {s, p, d, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      dev_dat = f[i];
      cyc(15);
      dev_clk = 1'b0;
      cyc(30);
      dev_clk = 1'b1;
      cyc(15);
    end
    dev_dat = 1'b1;
  endtask
  task automatic pop();
    @(negedge clk);
    reg_dat_re = 1'b1;
    @(negedge clk);
    reg_dat_re = 1'b0;
  endtask
  task automatic stat_clr();
    @(negedge clk);
    reg_stat_re = 1'b1;
    @(negedge clk);
    reg_stat_re = 1'b0;
  endtask
  task automatic wr(input logic [7:0] b, output int w);
    @(negedge clk);
    reg_dat_di = {24'h0, b};
    reg_dat_we = 1'b1;
    #1;
    w = 0;
    while (reg_dat_wait && w < 20000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    reg_dat_we = 1'b0;
  endtask
  task automatic wait_idle();
    int t = 0;
    while (reg_stat_do[2] && t < 2000) begin
      cyc(1);
      t++;
    end
  endtask
  // Device side of a host-to-device transfer: measures the inhibit, then clocks 11 edges
  task automatic dev_tx(input logic ack, output int inh, output logic start, output logic [9:0] bits);
    int t = 0;
    inh = 0;
    start = 1'b0;
    bits = '0;
    while (!ps2_clk_oe && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (!ps2_clk_oe) begin
      checks++;
      failures++;
      $display("FAIL tx_inhibit_start: got clk_oe=0 expected 1 within 5000 cycles");
      return;
    end
    while (ps2_clk_oe && inh < 5000) begin
      inh++;
      @(negedge clk);
    end
    start = ps2_data_oe;
    cyc(30);
    for (int i = 0; i < 11; i++) begin
      if (i == 10) dev_dat = ack;
      dev_clk = 1'b0;
      cyc(30);
      if (i < 10) bits[i] = ps2_data_i;
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      if (i < 10) cyc(30);
    end
  endtask
  initial begin
    int w0, w1, inh, n;
    logic st;
    logic [9:0] bits;
    logic [7:0] b;
    rxv[0] = '{8'h1C, 1'b0, 1'b1, 32'h0000001C, 1'b0};
    rxv[1] = '{8'h1C, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1};
    rxv[2] = '{8'hA5, 1'b1, 1'b1, 32'h000000A5, 1'b0};
    rxv[3] = '{8'h00, 1'b1, 1'b1, 32'h00000000, 1'b0};
    rxv[4] = '{8'hFF, 1'b1, 1'b1, 32'h000000FF, 1'b0};
    rxv[5] = '{8'h7F, 1'b0, 1'b1, 32'h0000007F, 1'b0};
    rxv[6] = '{8'h3C, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1};
    cyc(5);
    chk("rst_clk_oe", {31'h0, ps2_clk_oe}, 32'h0);
    chk("rst_data_oe", {31'h0, ps2_data_oe}, 32'h0);
    chk("rst_dat_do", reg_dat_do, 32'hFFFFFFFF);
    chk("rst_wait", {31'h0, reg_dat_wait}, 32'h0);
    chk("rst_stat", reg_stat_do, 32'h0);
    resetn = 1'b1;
    cyc(5);
    for (int i = 0; i < 7; i++) begin
      send_bits(frame(rxv[i].d, rxv[i].p, rxv[i].s), 11);
      cyc(20);
      chk($sformatf("rx%0d_do", i), reg_dat_do, rxv[i].exp_do);
      chk($sformatf("rx%0d_perr", i), {31'h0, reg_stat_do[4]}, {31'h0, rxv[i].exp_perr});
      pop();
      chk($sformatf("rx%0d_popped", i), reg_dat_do, 32'hFFFFFFFF);
      stat_clr();
      chk($sformatf("rx%0d_stat_clr", i), reg_stat_do, 32'h0);
    end
    for (int i = 1; i <= 9; i++) begin
      b = 8'(i);
      send_bits(frame(b, ~^b, 1'b1), 11);
    end
    cyc(20);
    chk("ovf_stat", reg_stat_do, 32'h3);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_rd%0d", i), reg_dat_do, 32'(i));
      pop();
    end
    chk("ovf_drained", reg_dat_do, 32'hFFFFFFFF);
    stat_clr();
    chk("ovf_clr", reg_stat_do, 32'h0);
    wr(8'hFF, w0);
    dev_tx(1'b0, inh, st, bits);
    chk("tx_ff_inhibit", 32'(inh), 32'd1200);
    chk("tx_ff_start", {31'h0, st}, 32'h1);
    chk("tx_ff_bits", {22'h0, bits}, 32'h3FF);
    wait_idle();
    chk("tx_ff_ack_stat", reg_stat_do, 32'h0);
    wr(8'hFF, w0);
    dev_tx(1'b1, inh, st, bits);
    chk("tx_ff2_bits", {22'h0, bits}, 32'h3FF);
    wait_idle();
    chk("tx_nack_stat", reg_stat_do, 32'h8);
    stat_clr();
    chk("tx_nack_clr", reg_stat_do, 32'h0);
    wr(8'hED, w0);
    chk("tx_ed_nowait", 32'(w0), 32'd0);
    fork
      wr(8'h02, w1);
      dev_tx(1'b0, inh, st, bits);
    join
    chk("tx_stall_long", {31'h0, w1 > 1000 && w1 < 20000}, 32'h1);
    chk("tx_ed_bits", {22'h0, bits}, 32'h3ED);
    dev_tx(1'b0, inh, st, bits);
    chk("tx_02_inhibit", 32'(inh), 32'd1200);
    chk("tx_02_bits", {22'h0, bits}, 32'h202);
    wait_idle();
    chk("tx_02_stat", reg_stat_do, 32'h0);
    send_bits(frame(8'h5A, 1'b1, 1'b1), 4);
    n = 0;
    while (!reg_stat_do[5] && n < 30000) begin
      cyc(1);
      n++;
    end
    chk("tmo_latency", {31'h0, n >= 23900 && n <= 24000}, 32'h1);
    chk("tmo_stat", reg_stat_do, 32'h20);
    stat_clr();
    chk("tmo_clr", reg_stat_do, 32'h0);
    send_bits(frame(8'h5A, 1'b1, 1'b1), 11);
    cyc(20);
    chk("tmo_next_rx", reg_dat_do, 32'h5A);
    pop();
    wr(8'h55, w0);
    n = 0;
    while (!ps2_clk_oe && n < 100) begin
      cyc(1);
      n++;
    end
    cyc(100);
    chk("rstinh_clk_oe_on", {31'h0, ps2_clk_oe}, 32'h1);
    resetn = 1'b0;
    #1;
    chk("rstinh_clk_oe_off", {31'h0, ps2_clk_oe}, 32'h0);
    chk("rstinh_stat", reg_stat_do, 32'h0);
    cyc(3);
    resetn = 1'b1;
    cyc(20);
    chk("rstinh_idle", {30'h0, ps2_clk_oe, reg_stat_do[2]}, 32'h0);
    send_bits(frame(8'h1C, 1'b0, 1'b1), 11);
    cyc(20);
    chk("rstinh_rx", reg_dat_do, 32'h1C);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
